// File: rtl/layer1_weight_sequencer.sv
// layer1_weight_sequencer
//
// Loads NODES weight words into an external per-node storage array. It then
// streams them back in node order over a valid/ready interface.
//
// Ports
//   clk, reset_n       clock; asynchronous active-low reset
//   loadStart          pulse: start loading all NODES words (EMPTY/READY only)
//   wInValid/wIn       incoming weight word for the current node
//   wInReady           word accepted on wInValid & wInReady
//   scanStart          pulse: stream stored words in node order (READY only)
//   scanValid/Ready    scan beat handshake
//   scanData/Index     stored word and its node index
//   scanLast           beat carries node NODES-1
//   weightsValid       complete set of NODES words written since reset/load
//   busy               LOAD or SCAN in progress
//   storeWriteEnable   storage write strobe (one cycle per accepted word)
//   storeNodeSelect    storage node select (write address / scan prefetch index)
//   storeWriteIn       storage write data
//   storeReadOut       storage read data, combinational in storeNodeSelect

`ifndef INPUT_LAYER_NODES
`define INPUT_LAYER_NODES 784
`endif
`ifndef RELU_NODES
`define RELU_NODES 16
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 8
`endif

module layer1_weight_sequencer #(
  parameter int unsigned NODES  = `INPUT_LAYER_NODES,
  parameter int unsigned WORD_W = `RELU_NODES * `LAYER_1_BIT_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              loadStart,
  input  logic              wInValid,
  input  logic [WORD_W-1:0] wIn,
  output logic              wInReady,
  input  logic              scanStart,
  output logic              scanValid,
  input  logic              scanReady,
  output logic [WORD_W-1:0] scanData,
  output logic [9:0]        scanIndex,
  output logic              scanLast,
  output logic              weightsValid,
  output logic              busy,
  output logic              storeWriteEnable,
  output logic [9:0]        storeNodeSelect,
  output logic [WORD_W-1:0] storeWriteIn,
  input  logic [WORD_W-1:0] storeReadOut
);

  localparam logic [9:0] LastIdx = 10'(NODES - 1);

  typedef enum logic [1:0] {StEmpty, StLoad, StReady, StScan} state_e;

  state_e     stateQ, stateD;
  logic [9:0] loadCount;
  logic       loadDone;   // last write just completed; raises weightsValid next cycle
  logic       fetchPend;  // storeNodeSelect holds an index not yet captured
  logic       settle;     // one-cycle settle after scanStart before first capture

  logic loadGo, scanGo, wAccept, lastWrite, scanDone, canCapture;

  always_comb begin
    loadGo     = loadStart && (stateQ == StEmpty || stateQ == StReady);
    scanGo     = scanStart && !loadStart && (stateQ == StReady);
    wInReady   = (stateQ == StLoad) && !storeWriteEnable;
    wAccept    = wInValid && wInReady;
    lastWrite  = (stateQ == StLoad) && storeWriteEnable && (storeNodeSelect == LastIdx);
    scanDone   = (stateQ == StScan) && scanValid && scanReady && scanLast;
    canCapture = (stateQ == StScan) && fetchPend && !settle && (!scanValid || scanReady);
    busy       = (stateQ == StLoad) || (stateQ == StScan);
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StEmpty: if (loadStart) stateD = StLoad;
      StLoad:  if (lastWrite) stateD = StReady;
      StReady: begin
        if (loadStart)      stateD = StLoad;
        else if (scanStart) stateD = StScan;
      end
      StScan:  if (scanDone) stateD = StReady;
      default: stateD = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ           <= StEmpty;
      loadCount        <= '0;
      loadDone         <= 1'b0;
      fetchPend        <= 1'b0;
      settle           <= 1'b0;
      weightsValid     <= 1'b0;
      storeWriteEnable <= 1'b0;
      storeNodeSelect  <= '0;
      storeWriteIn     <= '0;
      scanValid        <= 1'b0;
      scanData         <= '0;
      scanIndex        <= '0;
      scanLast         <= 1'b0;
    end else begin
      stateQ           <= stateD;
      storeWriteEnable <= 1'b0;
      loadDone         <= lastWrite;

      // A new load invalidates the stored set on the same edge.
      if (loadGo) begin
        loadCount    <= '0;
        weightsValid <= 1'b0;
      end else if (loadDone) begin
        weightsValid <= 1'b1;
      end

      // Write data/address are registered so the strobe and its operands are
      // glitch-free; wInReady stays low while the strobe is high.
      if (wAccept) begin
        storeWriteIn     <= wIn;
        storeNodeSelect  <= loadCount;
        storeWriteEnable <= 1'b1;
        if (loadCount != LastIdx) loadCount <= loadCount + 10'd1;
      end

      if (scanGo) begin
        storeNodeSelect <= '0;
        fetchPend       <= 1'b1;
        settle          <= 1'b1;
        scanValid       <= 1'b0;
        scanLast        <= 1'b0;
      end else if (stateQ == StScan) begin
        settle <= 1'b0;
        if (canCapture) begin
          scanData  <= storeReadOut;
          scanIndex <= storeNodeSelect;
          scanLast  <= (storeNodeSelect == LastIdx);
          scanValid <= 1'b1;
          if (storeNodeSelect == LastIdx) fetchPend <= 1'b0;
          else storeNodeSelect <= storeNodeSelect + 10'd1;
        end else if (scanValid && scanReady) begin
          scanValid <= 1'b0;
          scanLast  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer1_weight_sequencer.sv
module tb_layer1_weight_sequencer;

  localparam int unsigned N = 784;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          loadStart = 1'b0, wInValid = 1'b0, scanStart = 1'b0, scanReady = 1'b0;
  logic [W-1:0]  wIn;
  logic          wInReady, scanValid, scanLast, weightsValid, busy, storeWriteEnable;
  logic [W-1:0]  scanData, storeWriteIn, storeReadOut;
  logic [9:0]    scanIndex, storeNodeSelect;

  layer1_weight_sequencer #(.NODES(N), .WORD_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .loadStart(loadStart), .wInValid(wInValid), .wIn(wIn),
    .wInReady(wInReady), .scanStart(scanStart), .scanValid(scanValid), .scanReady(scanReady),
    .scanData(scanData), .scanIndex(scanIndex), .scanLast(scanLast),
    .weightsValid(weightsValid), .busy(busy), .storeWriteEnable(storeWriteEnable),
    .storeNodeSelect(storeNodeSelect), .storeWriteIn(storeWriteIn),
    .storeReadOut(storeReadOut)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input logic [9:0] i);
    return {i, 12'hABC, ~i};
  endfunction

  // Storage model: registered write, combinational read.
  logic [W-1:0] mem [1024];
  always @(posedge clk) if (storeWriteEnable) mem[storeNodeSelect] <= storeWriteIn;
  assign storeReadOut = mem[storeNodeSelect];

  // Monitor state
  logic [9:0]   tbAcc = '0;
  logic         chkLoad = 1'b0;
  int           weIdx = 0, weTotal = 0, accTotal = 0, seqErr = 0, stabErr = 0;
  int           scanExp = 0, beats = 0, scanErr = 0, holdErr = 0;
  logic         weSeen = 1'b0, holdPend = 1'b0;
  logic [W-1:0] weData, hData;
  logic [9:0]   weSel, hIdx;
  logic         hLast;

  assign wIn = pat(tbAcc);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tbAcc <= '0; weIdx <= 0; scanExp <= 0; weSeen <= 1'b0; holdPend <= 1'b0;
    end else begin
      if (loadStart) tbAcc <= '0;
      else if (wInValid && wInReady) tbAcc <= tbAcc + 10'd1;
      if (wInValid && wInReady) accTotal <= accTotal + 1;
      // Operands must still match in the cycle after the strobe falls.
      if (weSeen && (storeWriteIn != weData || storeNodeSelect != weSel)) stabErr <= stabErr + 1;
      weSeen <= storeWriteEnable; weData <= storeWriteIn; weSel <= storeNodeSelect;
      if (storeWriteEnable) begin
        weTotal <= weTotal + 1;
        if (chkLoad && (storeNodeSelect != 10'(weIdx) || storeWriteIn != pat(10'(weIdx))))
          seqErr <= seqErr + 1;
        weIdx <= weIdx + 1;
      end
      if (loadStart) weIdx <= 0;
      // Stalled beat must hold.
      if (holdPend && (!scanValid || scanData != hData || scanIndex != hIdx || scanLast != hLast))
        holdErr <= holdErr + 1;
      holdPend <= scanValid && !scanReady;
      hData <= scanData; hIdx <= scanIndex; hLast <= scanLast;
      if (scanValid && scanReady) begin
        beats <= beats + 1;
        if (scanIndex != 10'(scanExp) || scanData != pat(10'(scanExp)) ||
            scanLast != (scanExp == N - 1))
          scanErr <= scanErr + 1;
        scanExp <= scanExp + 1;
      end
      if (scanStart) scanExp <= 0;
    end
  end

  int nChecks = 0, nFails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {reset_n, loadStart, scanStart, wInValid} -> {busy, wInReady, weightsValid, WE, scanValid}
  typedef struct {
    logic       rst;
    logic       ls;
    logic       ss;
    logic       wv;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, base, accBase, beatBase, gap;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b00000}; // scanStart in EMPTY ignored
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b11000}; // enter LOAD
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b10010}; // accept -> strobe
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b11000}; // no accept while strobe high
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b11000}; // loadStart in LOAD ignored
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b10010};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b11000}; // scanStart in LOAD ignored
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000}; // reset aborts load

    for (int i = 0; i < 10; i++) begin
      reset_n = vecs[i].rst; loadStart = vecs[i].ls; scanStart = vecs[i].ss;
      wInValid = vecs[i].wv;
      tick();
      check($sformatf("vec%0d", i),
            {busy, wInReady, weightsValid, storeWriteEnable, scanValid}, vecs[i].exp);
    end
    check("rst_data", {scanData, storeWriteIn}, '0);
    check("rst_idx", {scanIndex, storeNodeSelect, scanLast}, '0);

    // Full load with wInValid held high.
    reset_n = 1'b1;
    tick();
    chkLoad = 1'b1; base = weTotal;
    wInValid = 1'b1; loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    for (cyc = 1; cyc < 1700; cyc++) begin
      tick();
      if (weightsValid) break;
    end
    wInValid = 1'b0;
    check("load_latency", cyc, 2 * N + 1);
    check("load_we_count", weTotal - base, N);
    check("load_seq_err", seqErr, 0);
    check("load_busy", busy, 1'b0);

    // Scan with scanReady toggling; loadStart mid-scan ignored.
    base = weTotal; beatBase = beats;
    scanReady = 1'b0; scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    check("scan_lat0", {busy, scanValid}, 2'b10);
    tick();
    check("scan_lat1", scanValid, 1'b0);
    tick();
    check("scan_lat2", {scanValid, scanIndex}, {1'b1, 10'd0});
    for (cyc = 0; cyc < 4000; cyc++) begin
      scanReady = ~scanReady;
      loadStart = (cyc == 10);
      tick();
      if (!busy) break;
    end
    loadStart = 1'b0; scanReady = 1'b0;
    check("scan_beats", beats - beatBase, N);
    check("scan_data_err", scanErr, 0);
    check("scan_hold_err", holdErr, 0);
    check("scan_no_we", weTotal - base, 0);
    check("scan_end", {busy, scanValid, weightsValid}, 3'b001);

    // loadStart and scanStart together in READY.
    loadStart = 1'b1; scanStart = 1'b1; wInValid = 1'b1;
    tick();
    loadStart = 1'b0; scanStart = 1'b0;
    check("both_start", {busy, wInReady, weightsValid, scanValid}, 4'b1100);

    // Reset at node 400 of the load.
    base = weTotal;
    for (cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (scanValid) break;
      if (weTotal - base >= 400) break;
    end
    check("mid_load_count", weTotal - base, 400);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ctl", {busy, wInReady, weightsValid, storeWriteEnable, scanValid, scanLast},
          6'b0);
    check("async_rst_data", {storeNodeSelect, storeWriteIn, scanData, scanIndex}, '0);
    @(posedge clk);
    #1 reset_n = 1'b1; wInValid = 1'b0;
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    tick(); tick(); tick();
    check("scan_after_abort", {busy, scanValid, weightsValid}, 3'b000);

    // Reload with random wInValid gaps.
    base = weTotal; accBase = accTotal; gap = 0;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    for (cyc = 0; cyc < N * 10; cyc++) begin
      int accPrev;
      accPrev = accTotal;
      if (gap > 0) begin wInValid = 1'b0; gap--; end
      else wInValid = 1'b1;
      tick();
      if (accTotal != accPrev) gap = $urandom_range(0, 5);
      if (weightsValid) break;
    end
    wInValid = 1'b0;
    check("gap_we_vs_acc", weTotal - base, accTotal - accBase);
    check("gap_we_count", weTotal - base, N);
    check("gap_stab_err", stabErr, 0);
    check("gap_seq_err", seqErr, 0);
    check("gap_wvalid", weightsValid, 1'b1);

    // Back-to-back scan of the reloaded data.
    beatBase = beats; scanReady = 1'b1; scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (!busy) break;
    end
    check("scan2_beats", beats - beatBase, N);
    check("scan2_data_err", scanErr, 0);
    check("scan2_end", {busy, scanValid, weightsValid}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
